// File: rtl/coproc_regs_pkg.sv
// Shared definitions for the crypto coprocessor register controller.
// Latency: n/a (constants, types and a helper function only).
// Backpressure: n/a.
package coproc_regs_pkg;

    // Byte addresses of the word-aligned register map.
    localparam logic [4:0] ADDR_OPA     = 5'h00;
    localparam logic [4:0] ADDR_OPB     = 5'h04;
    localparam logic [4:0] ADDR_CTRL    = 5'h08;
    localparam logic [4:0] ADDR_CMD     = 5'h0C;
    localparam logic [4:0] ADDR_STATUS  = 5'h10;
    localparam logic [4:0] ADDR_RES0    = 5'h14;
    localparam logic [4:0] ADDR_RES1    = 5'h18;
    localparam logic [4:0] ADDR_VERSION = 5'h1C;

    // STATUS register bit positions.
    localparam int STAT_BUSY    = 0;
    localparam int STAT_DONE    = 1;
    localparam int STAT_TIMEOUT = 2;
    localparam int STAT_CMD_ERR = 3;

    localparam int DEFAULT_TIMEOUT_CYCLES = 1024;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2
    } core_state_t;

    // Merge a write into a register honouring per-byte enables.
    function automatic logic [31:0] apply_strobe(input logic [31:0] old_val,
                                                 input logic [31:0] new_val,
                                                 input logic [3:0]  strobe);
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[b*8 +: 8] = strobe[b] ? new_val[b*8 +: 8] : old_val[b*8 +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/coproc_core_seq.sv
// Core launch sequencer: IDLE/LAUNCH/WAIT FSM, watchdog, start/abort pulses, result capture.
// Latency: core_start one cycle after launch; abort in WAIT cycle TIMEOUT_CYCLES.
// Backpressure: launch is only honoured in IDLE; the caller gates it with busy.
// Ports: clk/rst (async active-high); launch + launch_opcode from the CMD decoder;
// core_done/core_result0/1 from the core; busy, core_start, core_abort, core_opcode,
// captured result0/1 and one-cycle done_set/timeout_set events toward STATUS.
module coproc_core_seq
    import coproc_regs_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        launch,
    input  logic [7:0]  launch_opcode,
    input  logic        core_done,
    input  logic [31:0] core_result0,
    input  logic [31:0] core_result1,
    output logic        busy,
    output logic        core_start,
    output logic        core_abort,
    output logic [7:0]  core_opcode,
    output logic [31:0] result0,
    output logic [31:0] result1,
    output logic        done_set,
    output logic        timeout_set
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    core_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Pulses are decoded from state so a reset mid-operation kills them
    // immediately; done beats timeout because it is tested first.
    always_comb begin
        state_d     = state_q;
        core_start  = 1'b0;
        core_abort  = 1'b0;
        done_set    = 1'b0;
        timeout_set = 1'b0;
        case (state_q)
            IDLE: begin
                if (launch) state_d = LAUNCH;
            end
            LAUNCH: begin
                core_start = 1'b1;
                state_d    = WAIT;
            end
            WAIT: begin
                if (core_done) begin
                    done_set = 1'b1;
                    state_d  = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    core_abort  = 1'b1;
                    timeout_set = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Counter counts WAIT cycles: 0 in the first WAIT cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q       <= '0;
            core_opcode <= '0;
            result0     <= '0;
            result1     <= '0;
        end else begin
            if (state_q == LAUNCH) begin
                cnt_q <= '0;
            end else if (state_q == WAIT) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            if (state_q == IDLE && launch) begin
                core_opcode <= launch_opcode;
            end
            if (state_q == WAIT && core_done) begin
                result0 <= core_result0;
                result1 <= core_result1;
            end
        end
    end

    assign busy = (state_q != IDLE);

endmodule

// File: rtl/coproc_reg_ctrl.sv
// Register file and command controller behind the AXI-Lite backend request channels.
// Latency: write_done/read_done one cycle after the request is sampled; read data registered.
// Backpressure: requests are level-held; one request per direction every other cycle.
// Ports: s_axi_aclk clock, s_axi_aresetn async active-HIGH reset; write/read backend
// channels; core_* start/abort/done handshake toward the crypto core; irq level output.
module coproc_reg_ctrl
    import coproc_regs_pkg::*;
#(
    parameter int          TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter logic [31:0] VERSION        = 32'h0001_0000
) (
    input  logic        s_axi_aclk,
    input  logic        s_axi_aresetn,
    input  logic        write,
    input  logic [4:0]  write_addrs,
    input  logic [31:0] write_data,
    input  logic [3:0]  write_strobe,
    output logic        write_done,
    output logic        write_error,
    input  logic        read,
    input  logic [4:0]  read_addrs,
    output logic [31:0] read_data,
    output logic        read_done,
    output logic        read_error,
    output logic        core_start,
    output logic        core_abort,
    output logic [7:0]  core_opcode,
    output logic [31:0] core_operand_a,
    output logic [31:0] core_operand_b,
    input  logic        core_done,
    input  logic [31:0] core_result0,
    input  logic [31:0] core_result1,
    output logic        irq
);

    logic [31:0] opa_q, opb_q, cmd_q;
    logic        irq_en_q, done_q, timeout_q, cmd_err_q;
    logic [31:0] res0, res1;
    logic        busy, done_set, timeout_set;

    // A request is ignored while its done pulse is high (turnaround cycle).
    logic wr_req, rd_req;
    assign wr_req = write & ~write_done;
    assign rd_req = read & ~read_done;

    logic wr_err, cmd_ok, cmd_busy;
    always_comb begin
        wr_err   = 1'b0;
        cmd_ok   = 1'b0;
        cmd_busy = 1'b0;
        if (write_addrs[1:0] != 2'b00) begin
            wr_err = 1'b1;
        end else begin
            case (write_addrs)
                ADDR_RES0, ADDR_RES1, ADDR_VERSION: wr_err = 1'b1;
                ADDR_CMD: begin
                    if (busy) begin
                        wr_err   = 1'b1;
                        cmd_busy = 1'b1;
                    end else if (write_strobe != 4'b1111) begin
                        wr_err = 1'b1;
                    end else begin
                        cmd_ok = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    logic wr_fire, launch, status_wr;
    assign wr_fire   = wr_req & ~wr_err;
    assign launch    = wr_req & cmd_ok;
    assign status_wr = wr_fire & (write_addrs == ADDR_STATUS) & write_strobe[0];

    always_ff @(posedge s_axi_aclk or posedge s_axi_aresetn) begin
        if (s_axi_aresetn) begin
            write_done  <= 1'b0;
            write_error <= 1'b0;
            opa_q       <= '0;
            opb_q       <= '0;
            cmd_q       <= '0;
            irq_en_q    <= 1'b0;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
            cmd_err_q   <= 1'b0;
        end else begin
            write_done  <= wr_req;
            write_error <= wr_req & wr_err;
            if (wr_fire) begin
                case (write_addrs)
                    ADDR_OPA:  opa_q <= apply_strobe(opa_q, write_data, write_strobe);
                    ADDR_OPB:  opb_q <= apply_strobe(opb_q, write_data, write_strobe);
                    ADDR_CTRL: if (write_strobe[0]) irq_en_q <= write_data[0];
                    ADDR_CMD:  cmd_q <= write_data;
                    default: ;
                endcase
            end
            // Sticky bits: a hardware set in the same cycle as a W1C wins.
            done_q    <= done_set | (done_q &
                         ~(status_wr & write_data[STAT_DONE]));
            timeout_q <= timeout_set | (timeout_q &
                         ~(status_wr & write_data[STAT_TIMEOUT]));
            cmd_err_q <= (wr_req & cmd_busy) | (cmd_err_q &
                         ~(status_wr & write_data[STAT_CMD_ERR]));
        end
    end

    logic [31:0] rd_mux;
    always_comb begin
        rd_mux = '0;
        case (read_addrs)
            ADDR_OPA:     rd_mux = opa_q;
            ADDR_OPB:     rd_mux = opb_q;
            ADDR_CTRL:    rd_mux = {31'b0, irq_en_q};
            ADDR_CMD:     rd_mux = cmd_q;
            ADDR_STATUS:  rd_mux = {28'b0, cmd_err_q, timeout_q, done_q, busy};
            ADDR_RES0:    rd_mux = res0;
            ADDR_RES1:    rd_mux = res1;
            ADDR_VERSION: rd_mux = VERSION;
            default:      rd_mux = '0;
        endcase
    end

    // Sampled from current register state, so a same-cycle write is not visible.
    always_ff @(posedge s_axi_aclk or posedge s_axi_aresetn) begin
        if (s_axi_aresetn) begin
            read_done  <= 1'b0;
            read_error <= 1'b0;
            read_data  <= '0;
        end else begin
            read_done  <= rd_req;
            read_error <= rd_req & (read_addrs[1:0] != 2'b00);
            read_data  <= (rd_req && read_addrs[1:0] == 2'b00) ? rd_mux : '0;
        end
    end

    coproc_core_seq #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_seq (
        .clk          (s_axi_aclk),
        .rst          (s_axi_aresetn),
        .launch       (launch),
        .launch_opcode(write_data[7:0]),
        .core_done    (core_done),
        .core_result0 (core_result0),
        .core_result1 (core_result1),
        .busy         (busy),
        .core_start   (core_start),
        .core_abort   (core_abort),
        .core_opcode  (core_opcode),
        .result0      (res0),
        .result1      (res1),
        .done_set     (done_set),
        .timeout_set  (timeout_set)
    );

    assign core_operand_a = opa_q;
    assign core_operand_b = opb_q;
    assign irq            = irq_en_q & (done_q | timeout_q);

endmodule

// File: tb/tb_coproc_reg_ctrl.sv
// Directed bench for coproc_reg_ctrl with a 16-cycle watchdog.
// Latency: n/a.
// Backpressure: n/a.
module tb_coproc_reg_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        write, read, core_done;
    logic [4:0]  write_addrs, read_addrs;
    logic [31:0] write_data, core_result0, core_result1;
    logic [3:0]  write_strobe;
    logic        write_done, write_error, read_done, read_error;
    logic [31:0] read_data, core_operand_a, core_operand_b;
    logic        core_start, core_abort, irq;
    logic [7:0]  core_opcode;

    int n_cmp = 0;
    int n_err = 0;
    int start_cnt = 0;
    int abort_cnt = 0;

    always #5 clk = ~clk;

    coproc_reg_ctrl #(
        .TIMEOUT_CYCLES(16)
    ) dut (
        .s_axi_aclk    (clk),
        .s_axi_aresetn (rst),
        .write         (write),
        .write_addrs   (write_addrs),
        .write_data    (write_data),
        .write_strobe  (write_strobe),
        .write_done    (write_done),
        .write_error   (write_error),
        .read          (read),
        .read_addrs    (read_addrs),
        .read_data     (read_data),
        .read_done     (read_done),
        .read_error    (read_error),
        .core_start    (core_start),
        .core_abort    (core_abort),
        .core_opcode   (core_opcode),
        .core_operand_a(core_operand_a),
        .core_operand_b(core_operand_b),
        .core_done     (core_done),
        .core_result0  (core_result0),
        .core_result1  (core_result1),
        .irq           (irq)
    );

    always @(posedge clk) begin
        if (core_start) start_cnt++;
        if (core_abort) abort_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [4:0] a, input logic [31:0] d,
                             input logic [3:0] s, output logic err);
        logic seen;
        seen = 1'b0;
        write = 1'b1; write_addrs = a; write_data = d; write_strobe = s;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (write_done) begin
                seen = 1'b1;
                break;
            end
        end
        write = 1'b0;
        err = write_error;
        check("wr_handshake", 32'(seen), 32'd1);
    endtask

    task automatic bus_read(input logic [4:0] a, output logic [31:0] d, output logic err);
        logic seen;
        seen = 1'b0;
        read = 1'b1; read_addrs = a;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (read_done) begin
                seen = 1'b1;
                break;
            end
        end
        read = 1'b0;
        d = read_data;
        err = read_error;
        check("rd_handshake", 32'(seen), 32'd1);
    endtask

    task automatic pulse_done(input logic [31:0] r0, input logic [31:0] r1);
        core_done = 1'b1; core_result0 = r0; core_result1 = r1;
        @(posedge clk); #1;
        core_done = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got hang expected finish");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        logic        e;
        logic [31:0] d;
        int          abort_at;

        rst = 1'b1; write = 1'b0; read = 1'b0; core_done = 1'b0;
        write_addrs = '0; read_addrs = '0; write_data = '0; write_strobe = '0;
        core_result0 = '0; core_result1 = '0;
        #12;
        check("rst_done_pulses", {30'b0, write_done, read_done}, 32'd0);
        check("rst_core_pulses", {29'b0, core_start, core_abort, irq}, 32'd0);
        check("rst_opcode", 32'(core_opcode), 32'd0);
        check("rst_read_data", read_data, 32'd0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;

        // Byte-strobed OPA write.
        bus_write(5'h00, 32'hDEADBEEF, 4'b0011, e);
        check("opa_wr_err", 32'(e), 32'd0);
        bus_read(5'h00, d, e);
        check("opa_rd", d, 32'h0000BEEF);
        check("operand_a_live", core_operand_a, 32'h0000BEEF);

        // Launch and normal completion.
        bus_write(5'h0C, 32'h0000007B, 4'b1111, e);
        check("cmd_wr_err", 32'(e), 32'd0);
        check("core_start_hi", 32'(core_start), 32'd1);
        check("core_opcode", 32'(core_opcode), 32'h7B);
        @(posedge clk); #1;
        check("core_start_lo", 32'(core_start), 32'd0);
        bus_read(5'h10, d, e);
        check("status_busy", d, 32'h1);
        repeat (2) @(posedge clk);
        #1;
        pulse_done(32'h1234, 32'h5678);
        bus_read(5'h10, d, e);
        check("status_done", d, 32'h2);
        bus_read(5'h14, d, e);
        check("res0", d, 32'h1234);
        bus_read(5'h18, d, e);
        check("res1", d, 32'h5678);
        check("irq_masked", 32'(irq), 32'd0);
        check("start_count1", start_cnt, 32'd1);
        bus_write(5'h10, 32'hF, 4'b0001, e);
        bus_read(5'h10, d, e);
        check("status_w1c", d, 32'h0);

        // CMD while busy.
        bus_write(5'h0C, 32'h00000011, 4'b1111, e);
        bus_write(5'h0C, 32'h00000022, 4'b1111, e);
        check("cmd_busy_err", 32'(e), 32'd1);
        bus_read(5'h10, d, e);
        check("status_cmd_err", d, 32'h9);
        check("opcode_kept", 32'(core_opcode), 32'h11);
        bus_read(5'h0C, d, e);
        check("cmd_readback", d, 32'h11);
        pulse_done(32'h1, 32'h2);
        check("start_count2", start_cnt, 32'd2);
        bus_write(5'h10, 32'hF, 4'b0001, e);

        // core_done in the final watchdog cycle: done wins.
        bus_write(5'h0C, 32'h00000033, 4'b1111, e);
        repeat (16) @(posedge clk);
        #1;
        core_done = 1'b1; core_result0 = 32'hAAAA; core_result1 = 32'hBBBB;
        #1;
        check("done_beats_abort", 32'(core_abort), 32'd0);
        @(posedge clk); #1;
        core_done = 1'b0;
        bus_read(5'h10, d, e);
        check("status_done_race", d, 32'h2);
        bus_read(5'h14, d, e);
        check("res0_race", d, 32'hAAAA);
        check("abort_count0", abort_cnt, 32'd0);
        bus_write(5'h10, 32'hF, 4'b0001, e);

        // Timeout with irq enabled.
        bus_write(5'h08, 32'h1, 4'b1111, e);
        bus_read(5'h08, d, e);
        check("ctrl_rd", d, 32'h1);
        bus_write(5'h0C, 32'h00000005, 4'b1111, e);
        abort_at = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (core_abort) begin
                abort_at = i;
                break;
            end
        end
        check("abort_cycle", abort_at, 32'd16);
        @(posedge clk); #1;
        check("abort_one_cycle", 32'(core_abort), 32'd0);
        check("irq_on_timeout", 32'(irq), 32'd1);
        check("abort_count1", abort_cnt, 32'd1);
        bus_read(5'h10, d, e);
        check("status_timeout", d, 32'h4);
        bus_write(5'h10, 32'h4, 4'b0001, e);
        check("irq_cleared", 32'(irq), 32'd0);

        // Error cases and VERSION.
        bus_read(5'h1C, d, e);
        check("version", d, 32'h00010000);
        bus_read(5'h0D, d, e);
        check("rd_misalign_err", 32'(e), 32'd1);
        check("rd_misalign_data", d, 32'h0);
        bus_write(5'h14, 32'h5, 4'b1111, e);
        check("wr_res0_err", 32'(e), 32'd1);
        bus_write(5'h03, 32'h5, 4'b1111, e);
        check("wr_misalign_err", 32'(e), 32'd1);

        // Simultaneous read and write of OPB returns the old value.
        bus_write(5'h04, 32'h11111111, 4'b1111, e);
        @(posedge clk); #1;
        write = 1'b1; write_addrs = 5'h04; write_data = 32'h22222222; write_strobe = 4'b1111;
        read = 1'b1; read_addrs = 5'h04;
        @(posedge clk); #1;
        check("rw_both_done", {30'b0, write_done, read_done}, 32'd3);
        check("rw_old_value", read_data, 32'h11111111);
        write = 1'b0; read = 1'b0;
        bus_read(5'h04, d, e);
        check("rw_new_value", d, 32'h22222222);
        check("operand_b_live", core_operand_b, 32'h22222222);

        // Reset in WAIT.
        bus_write(5'h0C, 32'h00000044, 4'b1111, e);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midrst_pulses", {29'b0, core_start, core_abort, irq}, 32'd0);
        check("midrst_opcode", 32'(core_opcode), 32'd0);
        check("midrst_opa", core_operand_a, 32'd0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        pulse_done(32'h9999, 32'h9999);
        bus_read(5'h10, d, e);
        check("post_rst_status", d, 32'h0);
        bus_read(5'h14, d, e);
        check("post_rst_res0", d, 32'h0);
        check("post_rst_abort_count", abort_cnt, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/coproc_reg_ctrl.md
Name: coproc_reg_ctrl

Overview:
Register-file and command controller behind the AXI-Lite slave `axi`. It consumes that slave's backend write/read request channels and decodes a 5-bit byte-addressed register map. It launches instructions written to the CMD register into the crypto core over a start/done handshake, with a timeout watchdog. It holds operands, results and sticky status, and raises irq on completion.

Parameters:
TIMEOUT_CYCLES, 1024, max cycles in WAIT before the core is aborted (must be >=2)
VERSION, 32'h0001_0000, constant returned at VERSION register
CNT_W, $clog2(TIMEOUT_CYCLES), watchdog counter width (derived, not overridden)

Ports:
s_axi_aclk  in  1  clock
s_axi_aresetn  in  1  asynchronous, active-high reset (1 = reset, despite the name)
write  in  1  backend write request, level, held until write_done
write_addrs  in  5  byte address
write_data  in  32  write data
write_strobe  in  4  byte enables
write_done  out  1  one-cycle completion pulse
write_error  out  1  valid with write_done; 1 = SLVERR
read  in  1  backend read request, level, held until read_done
read_addrs  in  5  byte address
read_data  out  32  valid with read_done
read_done  out  1  one-cycle completion pulse
read_error  out  1  valid with read_done
core_start  out  1  one-cycle launch pulse
core_abort  out  1  one-cycle abort pulse on timeout
core_opcode  out  8  opcode latched at launch
core_operand_a  out  32  OPA register
core_operand_b  out  32  OPB register
core_done  in  1  core completion pulse
core_result0  in  32  valid with core_done
core_result1  in  32  valid with core_done
irq  out  1  level: CTRL.irq_en & (STATUS.done | STATUS.timeout)

Behaviour:
- Register map, word aligned:
  - 0x00 OPA RW.
  - 0x04 OPB RW.
  - 0x08 CTRL RW; bit0 = irq_en, bits[31:1] read 0.
  - 0x0C CMD: write launches; read returns last CMD value.
  - 0x10 STATUS: bit0 busy (RO), bit1 done (W1C), bit2 timeout (W1C), bit3 cmd_err (W1C).
  - 0x14 RES0 RO.
  - 0x18 RES1 RO.
  - 0x1C VERSION RO.
- Reset: all registers and outputs 0; FSM to IDLE; counter 0.
- Write path:
  - write=1 sampled at edge N while write_done=0 → write_done=1 for the cycle after edge N.
  - The request is ignored in the cycle write_done is high (turnaround).
  - Strobes apply per byte to OPA/OPB/CTRL.
- Write errors (write_error=1, no state change):
  - write_addrs[1:0]!=0.
  - Write to RES0, RES1 or VERSION.
  - CMD write with write_strobe!=4'b1111.
  - CMD write while busy; this also sets STATUS.cmd_err.
- Read path:
  - Same timing as the write path; read_data is registered with read_done.
  - read_addrs[1:0]!=0 → read_error=1, read_data=0.
- Read and write served in the same cycle: the read returns the pre-write value.
- Core FSM (IDLE, LAUNCH, WAIT):
  - IDLE→LAUNCH on an accepted CMD write. core_opcode<=write_data[7:0]; busy=1.
  - LAUNCH: core_start=1 for exactly one cycle; counter cleared; →WAIT.
  - WAIT:
    - core_done=1 → capture RES0/RES1, set done, busy=0, →IDLE.
    - Counter==TIMEOUT_CYCLES-1 without core_done → core_abort=1 for one cycle, set timeout, busy=0, →IDLE.
    - core_done and timeout in the same cycle: done wins, no abort.
  - core_done outside WAIT is ignored.
- Sticky bit set by hardware and W1C in the same cycle: set wins.
- OPA/OPB writes while busy are allowed; core_operand_a/b follow the registers live (the core latches them on core_start).
- Reset mid-operation: FSM to IDLE immediately; no abort pulse issued.

Decomposition:
- Package coproc_regs_pkg:
  - Address constants ADDR_OPA..ADDR_VERSION.
  - STATUS bit indices.
  - FSM state enum {IDLE, LAUNCH, WAIT}.
  - Default TIMEOUT_CYCLES.
- Sub-module coproc_core_seq: FSM, watchdog counter, start/abort pulses and result capture. The top level keeps address decode, registers and the read mux.

Test Plan:
1. Write OPA=0xDEADBEEF at 0x00, strobe 4'b0011 → write_done pulse, error 0; readback 0x0000BEEF.
2. Write CMD=0x0000007B at 0x0C, strobe 1111 → core_start one cycle later, core_opcode=0x7B, STATUS=0x1. Core_done with res0=0x1234, res1=0x5678 after 5 cycles → STATUS=0x2, RES0=0x1234, RES1=0x5678.
3. Second CMD write while busy → write_error=1, STATUS.cmd_err=1, no second core_start.
4. TIMEOUT_CYCLES=16, no core_done → core_abort on cycle 16 of WAIT, STATUS=0x4. irq=1 if CTRL=1; W1C write 0x4 to STATUS → irq=0.
5. Read 0x1C → 0x00010000. Read 0x0D → read_error=1, data 0. Write to 0x14 → write_error=1.
6. Assert reset in WAIT → all outputs 0 asynchronously, FSM IDLE. core_done after release → ignored, STATUS=0.
